// File: rtl/arm_memory_responder_if.sv
`default_nettype none
// ============================================================================
// arm_memory_responder_if : request/response bus between core and memory responder
// Revision: 1.0
// ============================================================================
interface arm_memory_responder_if;
  logic        req;
  logic        we;
  logic        byte_en;
  logic        seq;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        abort;
  logic        busy;

  modport master (
    output req, we, byte_en, seq, addr, wdata,
    input  rdata, ack, abort, busy
  );

  modport slave (
    input  req, we, byte_en, seq, addr, wdata,
    output rdata, ack, abort, busy
  );
endinterface
`default_nettype wire

// File: rtl/arm_memory_responder.sv
`default_nettype none
// ============================================================================
// arm_memory_responder : wait-state memory responder with word RAM and abort flag
// Optional macro ARM_MEM_SEQ_FAST_EN : sequential accesses skip the wait states
// Revision: 1.0
// ============================================================================
module arm_memory_responder #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  wire logic             clk1,
  input  wire logic             reset,
  arm_memory_responder_if.slave bus
);
  localparam int         AW          = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic       c_NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_byte;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_abort;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic          w_ready;
  logic          w_accept;
  logic          w_skip;
  logic          w_complete;
  logic [31:0]   w_op_addr;
  logic [31:0]   w_op_wdata;
  logic          w_op_we;
  logic          w_op_byte;
  logic          w_oob;
  logic [AW-1:0] w_idx;
  logic [4:0]    w_lane_lsb;
  logic [31:0]   w_word;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_accept = w_ready && bus.req;

`ifdef ARM_MEM_SEQ_FAST_EN
  logic [29:0] r_last_word;
  assign w_skip = c_NO_WAIT || (bus.seq && (bus.addr[31:2] == r_last_word + 30'd1));
`else
  logic w_unused_seq;
  assign w_unused_seq = bus.seq;
  assign w_skip       = c_NO_WAIT;
`endif

  // Zero-wait completions act on the live request; otherwise on the latched one.
  assign w_op_addr  = w_ready ? bus.addr    : r_addr;
  assign w_op_wdata = w_ready ? bus.wdata   : r_wdata;
  assign w_op_we    = w_ready ? bus.we      : r_we;
  assign w_op_byte  = w_ready ? bus.byte_en : r_byte;
  assign w_oob      = |w_op_addr[31:AW+2];
  assign w_idx      = w_op_addr[AW+1:2];
  assign w_lane_lsb = {w_op_addr[1:0], 3'b000};
  assign w_word     = r_mem[w_idx];
  assign w_complete = (w_accept && w_skip) || ((r_state == ST_WAIT) && (r_cnt == 4'd0));

  always_ff @(posedge clk1) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) w_next = w_skip ? ST_RESP : ST_WAIT;
        else          w_next = ST_IDLE;
      end
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_abort     <= 1'b0;
      r_rdata     <= 32'h0;
`ifdef ARM_MEM_SEQ_FAST_EN
      r_last_word <= 30'd0;
`endif
    end else begin
      r_ack   <= w_complete;
      r_abort <= w_complete && w_oob;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_cnt  <= c_WAIT_LOAD;
      end else if (r_state == ST_RESP) begin
        r_busy <= 1'b0;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_complete && !w_oob && !w_op_we)
        r_rdata <= w_op_byte ? {24'h0, w_word[w_lane_lsb +: 8]} : w_word;
`ifdef ARM_MEM_SEQ_FAST_EN
      if (w_complete && !w_oob) r_last_word <= w_op_addr[31:2];
`endif
    end
  end

  always_ff @(posedge clk1) begin
    if (w_accept) begin
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_we    <= bus.we;
      r_byte  <= bus.byte_en;
    end
  end

  // RAM is deliberately left out of reset; a reset edge only blocks the write.
  always_ff @(posedge clk1) begin
    if (!reset && w_complete && !w_oob && w_op_we) begin
      if (w_op_byte) r_mem[w_idx][w_lane_lsb +: 8] <= w_op_wdata[7:0];
      else           r_mem[w_idx]                  <= w_op_wdata;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.abort = r_abort;
  assign bus.busy  = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_arm_memory_responder.sv
`default_nettype none
// ============================================================================
// tb_arm_memory_responder : directed bench over four responders (WAIT_STATES 1/0/3/2)
// Revision: 1.0
// ============================================================================
module tb_arm_memory_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  sel;
  logic        req, we, byte_en, seq;
  logic [31:0] addr, wdata;
  logic [31:0] o_rdata;
  logic        o_ack, o_abort, o_busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] x_rdata;
  logic        x_abort;
  int          x_lat;

  arm_memory_responder_if bus0();
  arm_memory_responder_if bus1();
  arm_memory_responder_if bus2();
  arm_memory_responder_if bus3();

  assign bus0.req = req && (sel == 2'd0);
  assign bus1.req = req && (sel == 2'd1);
  assign bus2.req = req && (sel == 2'd2);
  assign bus3.req = req && (sel == 2'd3);
  assign bus0.we = we;  assign bus0.byte_en = byte_en;  assign bus0.seq = seq;
  assign bus1.we = we;  assign bus1.byte_en = byte_en;  assign bus1.seq = seq;
  assign bus2.we = we;  assign bus2.byte_en = byte_en;  assign bus2.seq = seq;
  assign bus3.we = we;  assign bus3.byte_en = byte_en;  assign bus3.seq = seq;
  assign bus0.addr = addr;  assign bus0.wdata = wdata;
  assign bus1.addr = addr;  assign bus1.wdata = wdata;
  assign bus2.addr = addr;  assign bus2.wdata = wdata;
  assign bus3.addr = addr;  assign bus3.wdata = wdata;

  arm_memory_responder #(.DEPTH(256), .WAIT_STATES(1)) u_ws1 (.clk1(clk), .reset(reset), .bus(bus0));
  arm_memory_responder #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (.clk1(clk), .reset(reset), .bus(bus1));
  arm_memory_responder #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (.clk1(clk), .reset(reset), .bus(bus2));
  arm_memory_responder #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (.clk1(clk), .reset(reset), .bus(bus3));

  always_comb begin
    o_rdata = bus0.rdata; o_ack = bus0.ack; o_abort = bus0.abort; o_busy = bus0.busy;
    case (sel)
      2'd1: begin o_rdata = bus1.rdata; o_ack = bus1.ack; o_abort = bus1.abort; o_busy = bus1.busy; end
      2'd2: begin o_rdata = bus2.rdata; o_ack = bus2.ack; o_abort = bus2.abort; o_busy = bus2.busy; end
      2'd3: begin o_rdata = bus3.rdata; o_ack = bus3.ack; o_abort = bus3.abort; o_busy = bus3.busy; end
      default: ;
    endcase
  end

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the selected responder ready; returns at the negedge where ack is seen.
  task automatic xfer(input logic iwe, input logic ib, input logic iseq,
                      input logic [31:0] iaddr, input logic [31:0] iwd);
    bit done;
    done = 1'b0;
    we = iwe; byte_en = ib; seq = iseq; addr = iaddr; wdata = iwd; req = 1'b1;
    x_lat = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      x_lat++;
      @(negedge clk);
      req = 1'b0;
      if (o_ack) begin
        done    = 1'b1;
        x_rdata = o_rdata;
        x_abort = o_abort;
      end
    end
    if (!done) tb_check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int fast_lat;
    reset = 1'b1; sel = 2'd0; req = 1'b0; we = 1'b0; byte_en = 1'b0; seq = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tb_check("rst_ack",   32'(o_ack),   32'd0);
    tb_check("rst_abort", 32'(o_abort), 32'd0);
    tb_check("rst_busy",  32'(o_busy),  32'd0);
    tb_check("rst_rdata", o_rdata,      32'h0);

    // Basic word write/read, WAIT_STATES=1
    xfer(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    tb_check("t1_wr_lat",   32'(x_lat),   32'd2);
    tb_check("t1_wr_abort", 32'(x_abort), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    tb_check("t1_rd_lat",   32'(x_lat),   32'd2);
    tb_check("t1_rd_data",  x_rdata,      32'hDEADBEEF);
    tb_check("t1_rd_abort", 32'(x_abort), 32'd0);
    @(posedge clk); @(negedge clk);
    tb_check("t1_ack_pulse", 32'(o_ack),  32'd0);
    tb_check("t1_busy_idle", 32'(o_busy), 32'd0);

    // Byte lanes
    xfer(1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344);
    xfer(1'b1, 1'b1, 1'b0, 32'h21, 32'h555555AA);
    xfer(1'b0, 1'b1, 1'b0, 32'h21, 32'h0);
    tb_check("t2_byte1", x_rdata, 32'h000000AA);
    xfer(1'b0, 1'b1, 1'b0, 32'h23, 32'h0);
    tb_check("t2_byte3", x_rdata, 32'h00000011);
    xfer(1'b0, 1'b0, 1'b0, 32'h22, 32'h0);
    tb_check("t2_word", x_rdata, 32'h1122AA44);

    // Out of range
    xfer(1'b1, 1'b0, 1'b0, 32'h0, 32'h0BADF00D);
    xfer(1'b1, 1'b0, 1'b0, 32'h400, 32'h5);
    tb_check("t3_oob_lat",   32'(x_lat),   32'd2);
    tb_check("t3_oob_abort", 32'(x_abort), 32'd1);
    tb_check("t3_oob_rdata", x_rdata,      32'h1122AA44);
    xfer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tb_check("t3_rd0_data",  x_rdata,      32'h0BADF00D);
    tb_check("t3_rd0_abort", 32'(x_abort), 32'd0);
    xfer(1'b1, 1'b0, 1'b0, 32'h3FC, 32'hCAFEF00D);
    xfer(1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0);
    tb_check("t3_top_data",  x_rdata,      32'hCAFEF00D);
    tb_check("t3_top_abort", 32'(x_abort), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0);
    tb_check("t3_hi_abort", 32'(x_abort), 32'd1);
    tb_check("t3_hi_rdata", x_rdata,      32'hCAFEF00D);

    // Back-to-back, WAIT_STATES=0
    sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'(32'hA0 + i * 4));
      tb_check("t4_wr_lat", 32'(x_lat), 32'd1);
    end
    we = 1'b0; byte_en = 1'b0; seq = 1'b0; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      @(posedge clk); @(negedge clk);
      tb_check("t4_b2b_ack",  32'(o_ack),  32'd1);
      tb_check("t4_b2b_busy", 32'(o_busy), 32'd1);
      tb_check("t4_b2b_data", o_rdata,     32'(32'hA0 + i * 4));
    end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    tb_check("t4_end_ack",  32'(o_ack),  32'd0);
    tb_check("t4_end_busy", 32'(o_busy), 32'd0);

    // Reset mid-transaction, WAIT_STATES=3
    sel = 2'd2;
    xfer(1'b1, 1'b0, 1'b0, 32'h30, 32'h12345678);
    tb_check("t5_wr_lat", 32'(x_lat), 32'd4);
    we = 1'b1; byte_en = 1'b0; addr = 32'h30; wdata = 32'h99; req = 1'b1;
    @(posedge clk); @(negedge clk);
    req = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    tb_check("t5_rst_ack",  32'(o_ack),  32'd0);
    tb_check("t5_rst_busy", 32'(o_busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (o_ack) seen = 1'b1;
    end
    tb_check("t5_no_ack", 32'(seen), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
    tb_check("t5_rd_lat",  32'(x_lat), 32'd4);
    tb_check("t5_rd_data", x_rdata,    32'h12345678);

    // Sequential accesses, WAIT_STATES=2
    sel = 2'd3;
`ifdef ARM_MEM_SEQ_FAST_EN
    fast_lat = 1;
`else
    fast_lat = 3;
`endif
    xfer(1'b1, 1'b0, 1'b0, 32'h40, 32'h1);
    xfer(1'b1, 1'b0, 1'b0, 32'h44, 32'h2);
    xfer(1'b1, 1'b0, 1'b0, 32'h4C, 32'h3);
    tb_check("t6_wr_lat", 32'(x_lat), 32'd3);
    xfer(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    tb_check("t6_rd40_lat",  32'(x_lat), 32'd3);
    tb_check("t6_rd40_data", x_rdata,    32'h1);
    xfer(1'b0, 1'b0, 1'b1, 32'h44, 32'h0);
    tb_check("t6_rd44_lat",  32'(x_lat), 32'(fast_lat));
    tb_check("t6_rd44_data", x_rdata,    32'h2);
    xfer(1'b0, 1'b0, 1'b1, 32'h4C, 32'h0);
    tb_check("t6_rd4c_lat",  32'(x_lat), 32'd3);
    tb_check("t6_rd4c_data", x_rdata,    32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
